// File: rtl/nbit_alu_pipe_pkg.sv
// Shared opcode encoding for the pipelined N-bit ALU and its combinational core.
package nbit_alu_pipe_pkg;

  localparam int OP_W = 3;

  typedef logic [OP_W-1:0] opcode_t;

  localparam opcode_t OP_AND = 3'b000;
  localparam opcode_t OP_OR  = 3'b001;
  localparam opcode_t OP_ADD = 3'b010;
  localparam opcode_t OP_NOT = 3'b011;
  localparam opcode_t OP_SUB = 3'b100;
  localparam opcode_t OP_SLT = 3'b101;
  localparam opcode_t OP_XOR = 3'b110;
  localparam opcode_t OP_NOR = 3'b111;

endpackage

// File: rtl/nbit_alu_core.sv
// Combinational N-bit ALU: eight logic/arithmetic ops with zero, carry and signed-overflow flags.
module nbit_alu_core
  import nbit_alu_pipe_pkg::*;
#(
  parameter int n = 4
) (
  input  logic [n-1:0]    a,
  input  logic [n-1:0]    b,
  input  logic [OP_W-1:0] opcode,
  output logic [n-1:0]    result,
  output logic            zero,
  output logic            carry,
  output logic            ovf
);

  logic [n:0] sum;
  logic [n:0] diff;
  logic       add_ovf;
  logic       sub_ovf;
  logic       lt;

  // Dedicated n+1-bit adders; bit n of diff is the no-borrow indication.
  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} + {1'b0, ~b} + {{n{1'b0}}, 1'b1};

  assign add_ovf = (a[n-1] == b[n-1]) && (sum[n-1] != a[n-1]);
  assign sub_ovf = (a[n-1] != b[n-1]) && (diff[n-1] != a[n-1]);

  // Signed less-than: the sign of a-b is only trustworthy when the subtract did not overflow.
  assign lt = diff[n-1] ^ sub_ovf;

  always_comb begin
    result = '0;
    carry  = 1'b0;
    ovf    = 1'b0;
    case (opcode)
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_ADD: begin
        result = sum[n-1:0];
        carry  = sum[n];
        ovf    = add_ovf;
      end
      OP_NOT: result = ~a;
      OP_SUB: begin
        result = diff[n-1:0];
        carry  = diff[n];
        ovf    = sub_ovf;
      end
      OP_SLT: result = {{(n-1){1'b0}}, lt};
      OP_XOR: result = a ^ b;
      OP_NOR: result = ~(a | b);
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/nbit_alu_pipe.sv
// Two-stage elastic valid/ready pipeline around nbit_alu_core, with a wrapping count of consumed results.
module nbit_alu_pipe
  import nbit_alu_pipe_pkg::*;
#(
  parameter int n     = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [n-1:0]     op_a,
  input  logic [n-1:0]     op_b,
  input  logic [OP_W-1:0]  opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [n-1:0]     result,
  output logic             flag_zero,
  output logic             flag_carry,
  output logic             flag_ovf,
  output logic [CNT_W-1:0] done_count
);

  logic [n-1:0]    s1_a;
  logic [n-1:0]    s1_b;
  logic [OP_W-1:0] s1_op;
  logic            s1_valid;
  logic            s2_valid;

  logic [n-1:0]    core_result;
  logic            core_zero;
  logic            core_carry;
  logic            core_ovf;

  logic            s1_load;
  logic            s2_load;
  logic            out_xfer;

  assign s2_load   = s1_valid & (~s2_valid | out_ready);
  assign s1_load   = in_valid & (~s1_valid | s2_load);
  assign in_ready  = ~s1_valid | ~s2_valid | out_ready;
  assign out_valid = s2_valid;
  assign out_xfer  = s2_valid & out_ready;

  nbit_alu_core #(
    .n (n)
  ) u_core (
    .a      (s1_a),
    .b      (s1_b),
    .opcode (s1_op),
    .result (core_result),
    .zero   (core_zero),
    .carry  (core_carry),
    .ovf    (core_ovf)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_a       <= '0;
      s1_b       <= '0;
      s1_op      <= '0;
      s1_valid   <= 1'b0;
      s2_valid   <= 1'b0;
      result     <= '0;
      flag_zero  <= 1'b0;
      flag_carry <= 1'b0;
      flag_ovf   <= 1'b0;
      done_count <= '0;
    end else begin
      if (s1_load) begin
        s1_a  <= op_a;
        s1_b  <= op_b;
        s1_op <= opcode;
      end

      if (s1_load)
        s1_valid <= 1'b1;
      else if (s2_load)
        s1_valid <= 1'b0;

      // Output registers only change when a new result moves in, so a stalled result stays put.
      if (s2_load) begin
        result     <= core_result;
        flag_zero  <= core_zero;
        flag_carry <= core_carry;
        flag_ovf   <= core_ovf;
        s2_valid   <= 1'b1;
      end else if (out_ready) begin
        s2_valid <= 1'b0;
      end

      if (out_xfer)
        done_count <= done_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_nbit_alu_pipe.sv
// Randomized and directed bench for nbit_alu_pipe against an arithmetic reference model with a result queue.
module tb_nbit_alu_pipe;
  import nbit_alu_pipe_pkg::*;

  localparam int N  = 4;
  localparam int CW = 8;
  localparam int M  = 1 << N;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [N-1:0]  op_a = '0;
  logic [N-1:0]  op_b = '0;
  logic [2:0]    opcode = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [N-1:0]  result;
  logic          flag_zero;
  logic          flag_carry;
  logic          flag_ovf;
  logic [CW-1:0] done_count;

  always #5 clk = ~clk;

  nbit_alu_pipe #(.n(N), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op_a       (op_a),
    .op_b       (op_b),
    .opcode     (opcode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .flag_zero  (flag_zero),
    .flag_carry (flag_carry),
    .flag_ovf   (flag_ovf),
    .done_count (done_count)
  );

  typedef struct {
    int res;
    int z;
    int c;
    int v;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   exp_done = 0;
  bit   held = 1'b0;
  int   held_val = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int sx(input int x);
    return (x >= M / 2) ? x - M : x;
  endfunction

  function automatic int out_of_range(input int s);
    return (s > M / 2 - 1 || s < -(M / 2)) ? 1 : 0;
  endfunction

  function automatic exp_t ref_alu(input int a, input int b, input int op);
    exp_t e;
    int sa = sx(a);
    int sb = sx(b);
    int t;
    e.res = 0;
    e.c = 0;
    e.v = 0;
    case (op)
      0: e.res = a & b;
      1: e.res = a | b;
      2: begin
        t = a + b;
        e.res = t % M;
        e.c = (t >= M) ? 1 : 0;
        e.v = out_of_range(sa + sb);
      end
      3: e.res = (~a) & (M - 1);
      4: begin
        e.res = (a - b + M) % M;
        e.c = (a >= b) ? 1 : 0;
        e.v = out_of_range(sa - sb);
      end
      5: e.res = (sa < sb) ? 1 : 0;
      6: e.res = a ^ b;
      default: e.res = (~(a | b)) & (M - 1);
    endcase
    e.z = (e.res == 0) ? 1 : 0;
    return e;
  endfunction

  // One cycle: drive at the falling edge, then judge what the next rising edge will transfer.
  task automatic step(input bit iv, input int a, input int b, input int op, input bit ordy,
                      output bit acc);
    exp_t e;
    int cur;
    @(negedge clk);
    in_valid = iv;
    op_a = N'(a);
    op_b = N'(b);
    opcode = 3'(op);
    out_ready = ordy;
    #1;
    chk("done_count", int'(done_count), exp_done % (1 << CW));
    acc = in_valid && in_ready;
    cur = int'({result, flag_zero, flag_carry, flag_ovf});
    if (held) begin
      chk("stall_valid", int'(out_valid), 1);
      chk("stall_hold", cur, held_val);
    end
    held = 1'b0;
    if (out_valid) begin
      if (out_ready) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out", int'(out_valid), 0);
        end else begin
          e = exp_q.pop_front();
          chk("result", int'(result), e.res);
          chk("flag_zero", int'(flag_zero), e.z);
          chk("flag_carry", int'(flag_carry), e.c);
          chk("flag_ovf", int'(flag_ovf), e.v);
        end
        exp_done++;
      end else begin
        held = 1'b1;
        held_val = cur;
      end
    end
    if (acc) exp_q.push_back(ref_alu(a, b, op));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    exp_q.delete();
    exp_done = 0;
    held = 1'b0;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_result", int'(result), 0);
    chk("rst_flags", int'({flag_zero, flag_carry, flag_ovf}), 0);
    chk("rst_done_count", int'(done_count), 0);
    chk("rst_in_ready", int'(in_ready), 1);
  endtask

  task automatic dir_op(input string tag, input int a, input int b, input int op,
                        input int er, input int ez, input int ec, input int ev);
    bit acc;
    int lat;
    step(1'b1, a, b, op, 1'b1, acc);
    chk({tag, "_acc"}, int'(acc), 1);
    lat = 0;
    for (int i = 1; i <= 6; i++) begin
      step(1'b0, 0, 0, 0, 1'b1, acc);
      if (out_valid) begin
        lat = i;
        break;
      end
    end
    chk({tag, "_latency"}, lat, 2);
    chk({tag, "_result"}, int'(result), er);
    chk({tag, "_zero"}, int'(flag_zero), ez);
    chk({tag, "_carry"}, int'(flag_carry), ec);
    chk({tag, "_ovf"}, int'(flag_ovf), ev);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit acc;
    int cnt;
    int a;
    int b;

    do_reset();

    dir_op("slt_neg_pos", 4'b1110, 4'b0001, 5, 1, 0, 0, 0);
    dir_op("slt_pos_neg", 4'b0001, 4'b1110, 5, 0, 1, 0, 0);
    dir_op("add_ovf",     4'b0111, 4'b0001, 2, 8, 0, 0, 1);
    dir_op("add_carry",   4'b1111, 4'b0001, 2, 0, 1, 1, 0);
    dir_op("sub_equal",   4'b0011, 4'b0011, 4, 0, 1, 1, 0);
    dir_op("sub_ovf",     4'b1000, 4'b0001, 4, 7, 0, 1, 1);

    // Backpressure: three offers with the consumer stalled, then release.
    cnt = 0;
    step(1'b1, 5, 3, 0, 1'b0, acc); cnt += int'(acc);
    step(1'b1, 9, 6, 6, 1'b0, acc); cnt += int'(acc);
    step(1'b1, 2, 4, 7, 1'b0, acc); cnt += int'(acc);
    chk("bp_accepted", cnt, 2);
    chk("bp_in_ready", int'(in_ready), 0);
    step(1'b1, 2, 4, 7, 1'b0, acc);
    chk("bp_still_stalled", int'(acc), 0);
    step(1'b1, 2, 4, 7, 1'b1, acc);
    chk("bp_acc_third", int'(acc), 1);
    chk("bp_out1", int'(out_valid), 1);
    step(1'b0, 0, 0, 0, 1'b1, acc);
    chk("bp_out2", int'(out_valid), 1);
    step(1'b0, 0, 0, 0, 1'b1, acc);
    chk("bp_out3", int'(out_valid), 1);
    chk("bp_drained", exp_q.size(), 0);

    // Reset with both stages occupied.
    step(1'b1, 3, 4, 2, 1'b0, acc);
    step(1'b1, 7, 7, 4, 1'b0, acc);
    step(1'b0, 0, 0, 0, 1'b0, acc);
    chk("full_in_ready", int'(in_ready), 0);
    do_reset();

    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 3) != 0), $urandom_range(0, M - 1), $urandom_range(0, M - 1),
           $urandom_range(0, 7), ($urandom_range(0, 3) != 0), acc);
    end
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) step(1'b0, 0, 0, 0, 1'b1, acc);
    chk("rand_drained", exp_q.size(), 0);

    // Counter wrap: 256 back-to-back ADDs from a cleared counter.
    do_reset();
    cnt = 0;
    for (int i = 0; i < 256; i++) begin
      a = $urandom_range(0, M - 1);
      b = $urandom_range(0, M - 1);
      step(1'b1, a, b, 2, 1'b1, acc);
      cnt += int'(acc);
    end
    chk("wrap_accepted", cnt, 256);
    step(1'b0, 0, 0, 0, 1'b1, acc);
    step(1'b0, 0, 0, 0, 1'b1, acc);
    chk("wrap_pre", int'(done_count), 255);
    step(1'b0, 0, 0, 0, 1'b1, acc);
    chk("wrap_done_count", int'(done_count), 0);
    chk("wrap_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/nbit_alu_pipe.md
Name: nbit_alu_pipe

Overview:
Registered, handshaked wrapper around the team's combinational N-bit ALU operations: AND, OR, ADD, SUB, NOT, SLT, XOR and NOR.
- Accepts an operand pair and an opcode over a valid/ready interface.
- Computes the result in a two-stage elastic pipeline.
- Delivers the result with zero, carry and overflow flags to the downstream consumer.
- Sits between the operand/decode logic and the register writeback, so that SLT and the arithmetic paths are timing-isolated.

Parameters:
n, 4, operand/result width in bits (n >= 2)
CNT_W, 8, width of the completed-transaction counter

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  upstream presents op_a/op_b/opcode
in_ready  output  1  block can accept this cycle
op_a  input  n  operand A (two's complement where signed)
op_b  input  n  operand B
opcode  input  3  operation select
out_valid  output  1  result/flags valid
out_ready  input  1  downstream accepts result
result  output  n  operation result
flag_zero  output  1  result == 0
flag_carry  output  1  adder carry out / no-borrow
flag_ovf  output  1  signed overflow
done_count  output  CNT_W  number of results consumed (out_valid & out_ready), wraps

Behaviour:
- Reset (rst=1 at a clk edge):
  - Stage-1 and stage-2 valids cleared.
  - result, all flags and done_count set to 0.
  - out_valid=0 on the cycle after reset.
  - in_ready is 1 once reset is deasserted.
  - A transaction in flight when reset is asserted is discarded; no partial output.
- Transfer rules:
  - Input transfer occurs when in_valid & in_ready.
  - Output transfer occurs when out_valid & out_ready.
- Stage 1: registers op_a, op_b, opcode and s1_valid on input transfer.
- Stage 2: computes from the stage-1 registers, then registers result, flags and s2_valid.
- Advance rules:
  - s2 loads when s1_valid & (!s2_valid | out_ready).
  - s1 loads when in_valid & (!s1_valid | s2 loads).
  - in_ready = !s1_valid | (!s2_valid | out_ready), combinational.
- Latency and throughput:
  - Accept at edge k gives out_valid high after edge k+1 with no stall.
  - One transaction per cycle sustained.
- Stall: while out_valid & !out_ready, result and flags are held stable; nothing is dropped or duplicated.
- Simultaneous: output consumed and new input accepted in the same cycle is legal, with full throughput.
- Opcodes:
  - 000 AND: a&b.
  - 001 OR: a|b.
  - 010 ADD: a+b.
  - 011 NOT: ~a.
  - 100 SUB: a+~b+1.
  - 101 SLT: signed a<b, 1 zero-extended to n bits, else 0; a==b gives 0.
  - 110 XOR.
  - 111 NOR.
- Flags:
  - flag_zero = (result==0) for all opcodes.
  - ADD: flag_carry = bit n of the (n+1)-bit sum. flag_ovf = operand signs equal and result sign differs.
  - SUB: flag_carry = 1 when there is no borrow (a>=b unsigned). flag_ovf = operand signs differ and result sign differs from a.
  - All other opcodes: flag_carry=0, flag_ovf=0.
  - SLT uses signed comparison derived from the subtract result sign XOR overflow; it must agree with the mixed-sign rule (a neg, b pos gives 1; a pos, b neg gives 0).
- Widths: all arithmetic is modulo 2^n; the carry is taken from a dedicated n+1-bit sum.
- done_count increments by 1 on each output transfer and wraps from 2^CNT_W-1 to 0.

Decomposition:
- Shared package holds:
  - opcode localparams: OP_AND=3'b000, OP_OR=3'b001, OP_ADD=3'b010, OP_NOT=3'b011, OP_SUB=3'b100, OP_SLT=3'b101, OP_XOR=3'b110, OP_NOR=3'b111.
  - opcode width constant: 3.
- One combinational sub-module, nbit_alu_core (a, b, opcode -> result, zero, carry, ovf), instantiated between stage-1 and stage-2 registers.
- Pipeline and handshake control stay in nbit_alu_pipe.

Test Plan:
- n=4, out_ready=1:
  - SLT a=4'b1110, b=4'b0001 -> result=4'b0001, zero=0, out_valid 2 cycles after accept.
  - Then SLT a=4'b0001, b=4'b1110 -> result=4'b0000, zero=1.
- ADD a=4'b0111, b=4'b0001 -> result=4'b1000, ovf=1, carry=0. ADD a=4'b1111, b=4'b0001 -> result=0, carry=1, zero=1, ovf=0.
- SUB a=4'b0011, b=4'b0011 -> result=0, zero=1, carry=1, ovf=0. SUB a=4'b1000, b=4'b0001 -> result=4'b0111, ovf=1, carry=1.
- Backpressure:
  - Stimulus: out_ready=0, in_valid=1 with 3 distinct ops.
  - Response: exactly 2 accepted and in_ready=0; first result held stable.
  - Then out_ready=1: results emerge in order, one per cycle, none lost.
- Reset mid-flight: assert rst one cycle with both stages valid -> next cycle out_valid=0, result=0, done_count=0, in_ready=1.
- Counter wrap: stream 256 back-to-back ADDs with out_ready=1 (CNT_W=8) -> done_count returns to 0 after the 256th output transfer; no idle cycles in the stream.
